// File: rtl/param_step_cpu.sv
// Parametrised stepped load/store CPU core: one instruction per accepted step pulse,
// with carry flag, halt state, retired-instruction counter and one-hot debug view.
module param_step_cpu #(
    parameter int DATA_W  = 8,
    parameter int RA_W    = 2,
    parameter int DMEM_AW = 5,
    parameter int PC_W    = 8,
    parameter int CNT_W   = 16,
    localparam int INSTR_W = 2 + 3 * RA_W
) (
    input  logic                  CLK,
    input  logic                  reset,
    input  logic                  step,
    input  logic [INSTR_W-1:0]    instr,
    input  logic                  instr_valid,
    output logic [PC_W-1:0]       pc,
    output logic                  instr_ready,
    output logic                  reg_write_stb,
    output logic [DATA_W-1:0]     reg_write_val,
    output logic                  carry,
    output logic                  halted,
    output logic                  busy,
    output logic [CNT_W-1:0]      retired,
    input  logic [(2**RA_W):0]    dbg_sel,
    output logic [DATA_W-1:0]     dbg_data
);

    localparam int unsigned NREG  = 2 ** RA_W;
    localparam int unsigned DEPTH = 2 ** DMEM_AW;
    localparam logic [NREG:0] SEL_ONE = 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_HALT
    } state_t;

    state_t               state;
    logic [INSTR_W-1:0]   ir;
    logic [DATA_W-1:0]    regs [NREG];
    logic [DATA_W-1:0]    mem  [DEPTH];

    logic [1:0]           op;
    logic [RA_W-1:0]      fa, fb, fc;
    logic [DATA_W-1:0]    ra, rb;
    logic [DATA_W:0]      sum;
    logic [DMEM_AW-1:0]   addr;
    logic [1:0]           jsel;
    logic [PC_W-1:0]      pc_inc;

    assign op     = ir[INSTR_W-1 -: 2];
    assign fa     = ir[3*RA_W-1 -: RA_W];
    assign fb     = ir[2*RA_W-1 -: RA_W];
    assign fc     = ir[RA_W-1:0];
    assign ra     = regs[fa];
    assign rb     = regs[fb];
    assign sum    = {1'b0, ra} + {1'b0, rb};
    assign addr   = DMEM_AW'(ra) + DMEM_AW'(fc);
    assign jsel   = 2'(fc);
    assign pc_inc = pc + PC_W'(1);

    assign instr_ready = (state == S_IDLE);
    assign busy        = (state == S_EXEC);
    assign halted      = (state == S_HALT);

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state         <= S_IDLE;
            ir            <= '0;
            pc            <= '0;
            carry         <= 1'b0;
            retired       <= '0;
            reg_write_stb <= 1'b0;
            reg_write_val <= '0;
            for (int unsigned i = 0; i < NREG; i++)
                regs[i] <= '0;
            for (int unsigned i = 0; i < DEPTH; i++)
                mem[i] <= DATA_W'(i[3:0]);
        end else begin
            reg_write_stb <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (step && instr_valid) begin
                        ir    <= instr;
                        state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    retired <= retired + 1'b1;
                    state   <= S_IDLE;
                    pc      <= pc_inc;
                    case (op)
                        2'b00: begin
                            regs[fc]      <= sum[DATA_W-1:0];
                            carry         <= sum[DATA_W];
                            reg_write_stb <= 1'b1;
                            reg_write_val <= sum[DATA_W-1:0];
                        end
                        2'b01: begin
                            regs[fb]      <= mem[addr];
                            reg_write_stb <= 1'b1;
                            reg_write_val <= mem[addr];
                        end
                        2'b10: begin
                            mem[addr] <= rb;
                        end
                        default: begin
                            case (jsel)
                                2'b00:   pc <= pc_inc;
                                2'b01:   pc <= pc + PC_W'(2);
                                2'b10:   pc <= pc - PC_W'(1);
                                default: begin
                                    pc    <= pc;
                                    state <= S_HALT;
                                end
                            endcase
                        end
                    endcase
                end
                default: state <= S_HALT;
            endcase
        end
    end

    // Invalid (zero or multi-hot) selects read back as all ones
    always_comb begin
        dbg_data = '1;
        if ((dbg_sel != '0) && ((dbg_sel & (dbg_sel - SEL_ONE)) == '0)) begin
            if (dbg_sel[NREG]) begin
                dbg_data = DATA_W'(pc);
            end else begin
                for (int unsigned i = 0; i < NREG; i++)
                    if (dbg_sel[i])
                        dbg_data = regs[i];
            end
        end
    end

endmodule

// File: tb/tb_param_step_cpu.sv
// Directed self-checking bench for param_step_cpu with default parameters (8-bit data,
// 4 registers, 32-word memory, 8-bit pc, 16-bit retired counter).
module tb_param_step_cpu;

    logic        CLK;
    logic        reset;
    logic        step;
    logic [7:0]  instr;
    logic        instr_valid;
    logic [7:0]  pc;
    logic        instr_ready;
    logic        reg_write_stb;
    logic [7:0]  reg_write_val;
    logic        carry;
    logic        halted;
    logic        busy;
    logic [15:0] retired;
    logic [4:0]  dbg_sel;
    logic [7:0]  dbg_data;

    int n_checks;
    int n_fail;

    param_step_cpu #(
        .DATA_W  (8),
        .RA_W    (2),
        .DMEM_AW (5),
        .PC_W    (8),
        .CNT_W   (16)
    ) dut (
        .CLK           (CLK),
        .reset         (reset),
        .step          (step),
        .instr         (instr),
        .instr_valid   (instr_valid),
        .pc            (pc),
        .instr_ready   (instr_ready),
        .reg_write_stb (reg_write_stb),
        .reg_write_val (reg_write_val),
        .carry         (carry),
        .halted        (halted),
        .busy          (busy),
        .retired       (retired),
        .dbg_sel       (dbg_sel),
        .dbg_data      (dbg_data)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic chk_reg(input int idx, input logic [7:0] exp, input string tag);
        dbg_sel = 5'(1 << idx);
        #1;
        check_eq(tag, dbg_data, exp);
        dbg_sel = '0;
    endtask

    // Present an instruction and return 1 time unit after the accepting edge
    task automatic issue(input logic [7:0] ins);
        @(negedge CLK);
        instr       = ins;
        instr_valid = 1'b1;
        step        = 1'b1;
        @(posedge CLK);
        #1;
        step        = 1'b0;
        instr_valid = 1'b0;
    endtask

    task automatic finish_exec;
        @(posedge CLK);
        #1;
    endtask

    task automatic do_step(input logic [7:0] ins);
        issue(ins);
        finish_exec();
    endtask

    task automatic pulse_reset;
        @(negedge CLK);
        reset = 1'b0;
        @(negedge CLK);
        reset = 1'b1;
        #1;
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        reset       = 1'b0;
        step        = 1'b0;
        instr_valid = 1'b0;
        instr       = '0;
        dbg_sel     = '0;
        #12;
        @(negedge CLK);
        reset = 1'b1;
        #1;

        // Reset state
        check_eq("rst_pc", pc, 8'h00);
        check_eq("rst_retired", retired, 16'd0);
        check_eq("rst_stb", reg_write_stb, 1'b0);
        check_eq("rst_val", reg_write_val, 8'h00);
        check_eq("rst_carry", carry, 1'b0);
        check_eq("rst_halted", halted, 1'b0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_ready", instr_ready, 1'b1);
        chk_reg(2, 8'h00, "rst_r2");

        // 1: LOAD R1,[R0+3]
        issue(8'h47);
        check_eq("t1_busy", busy, 1'b1);
        check_eq("t1_ready_exec", instr_ready, 1'b0);
        finish_exec();
        check_eq("t1_stb", reg_write_stb, 1'b1);
        check_eq("t1_val", reg_write_val, 8'h03);
        check_eq("t1_pc", pc, 8'h01);
        check_eq("t1_retired", retired, 16'd1);
        check_eq("t1_ready", instr_ready, 1'b1);
        chk_reg(1, 8'h03, "t1_r1");
        @(posedge CLK);
        #1;
        check_eq("t1_stb_once", reg_write_stb, 1'b0);

        // 2: ADD chain and carry
        do_step(8'h16);                 // R2 = R1 + R1
        do_step(8'h2B);                 // R3 = R2 + R2
        chk_reg(2, 8'h06, "t2_r2");
        chk_reg(3, 8'h0C, "t2_r3");
        check_eq("t2_carry0", carry, 1'b0);
        do_step(8'h73);                 // R0 = M[R3+3] = M[15]
        chk_reg(0, 8'h0F, "t2_r0");
        do_step(8'h01);                 // R1 = 30
        do_step(8'h15);                 // 60
        do_step(8'h15);                 // 120
        do_step(8'h15);                 // 240
        do_step(8'h11);                 // R1 = R1 + R0 = 255
        chk_reg(1, 8'hFF, "t2_r1_ff");
        check_eq("t2_carry_ff", carry, 1'b0);
        do_step(8'h15);                 // R1 = 0xFF + 0xFF
        chk_reg(1, 8'hFE, "t2_r1_fe");
        check_eq("t2_carry1", carry, 1'b1);
        check_eq("t2_val", reg_write_val, 8'hFE);
        check_eq("t2_pc", pc, 8'd10);
        check_eq("t2_retired", retired, 16'd10);

        // 3: address wrap, STORE then LOAD
        do_step(8'h5B);                 // R2 = M[(0xFE+3) mod 32] = M[1]
        chk_reg(2, 8'h01, "t3_wrap_load");
        check_eq("t3_load_keeps_carry", carry, 1'b1);
        do_step(8'h03);                 // R3 = R0 + R0 = 30
        do_step(8'h39);                 // R1 = R3 + R2 = 31
        chk_reg(1, 8'h1F, "t3_r1");
        do_step(8'h96);                 // M[(31+2) mod 32] = R1
        check_eq("t3_store_stb", reg_write_stb, 1'b0);
        check_eq("t3_store_val", reg_write_val, 8'h1F);
        do_step(8'h52);                 // R0 = M[1]
        check_eq("t3_load_stb", reg_write_stb, 1'b1);
        chk_reg(0, 8'h1F, "t3_r0");
        check_eq("t3_retired", retired, 16'd15);

        // 6: debug view
        dbg_sel = 5'b00001; #1; check_eq("t6_sel_r0", dbg_data, 8'h1F);
        dbg_sel = 5'b10000; #1; check_eq("t6_sel_pc", dbg_data, 8'h0F);
        dbg_sel = 5'b00011; #1; check_eq("t6_sel_multi", dbg_data, 8'hFF);
        dbg_sel = 5'b00000; #1; check_eq("t6_sel_none", dbg_data, 8'hFF);

        // 4: jumps, invalid step, dropped step
        pulse_reset();
        check_eq("t4_rst_pc", pc, 8'h00);
        chk_reg(0, 8'h00, "t4_rst_r0");
        do_step(8'hC2);
        check_eq("t4_jm1", pc, 8'hFF);
        do_step(8'hC1);
        check_eq("t4_jp2", pc, 8'h01);
        check_eq("t4_jump_val", reg_write_val, 8'h00);
        @(negedge CLK);
        step = 1'b1;
        instr = 8'hC1;
        instr_valid = 1'b0;
        @(posedge CLK);
        #1;
        step = 1'b0;
        check_eq("t4_invalid_busy", busy, 1'b0);
        @(posedge CLK);
        #1;
        check_eq("t4_invalid_pc", pc, 8'h01);
        check_eq("t4_invalid_ret", retired, 16'd2);
        @(negedge CLK);
        instr = 8'hC0;
        instr_valid = 1'b1;
        step = 1'b1;
        @(posedge CLK);
        #1;
        instr = 8'hC1;
        @(posedge CLK);
        #1;
        step = 1'b0;
        instr_valid = 1'b0;
        check_eq("t4_drop_pc", pc, 8'h02);
        @(posedge CLK);
        #1;
        check_eq("t4_drop_pc_later", pc, 8'h02);
        check_eq("t4_drop_ret", retired, 16'd3);

        // 5: HALT at pc 5
        do_step(8'hC1);                 // pc 4
        do_step(8'hC0);                 // pc 5
        do_step(8'hC3);
        check_eq("t5_halted", halted, 1'b1);
        check_eq("t5_ready", instr_ready, 1'b0);
        check_eq("t5_pc", pc, 8'h05);
        check_eq("t5_ret", retired, 16'd6);
        dbg_sel = 5'b10000; #1; check_eq("t6_sel_pc5", dbg_data, 8'h05);
        dbg_sel = '0;
        do_step(8'hC0);
        check_eq("t5_halt_pc", pc, 8'h05);
        check_eq("t5_halt_ret", retired, 16'd6);
        check_eq("t5_halt_stays", halted, 1'b1);

        // 5: reset during EXEC
        pulse_reset();
        check_eq("t5_rst_halted", halted, 1'b0);
        do_step(8'h47);                 // R1 = 3
        do_step(8'h16);                 // R2 = 6
        do_step(8'hA5);                 // M[7] = 3
        do_step(8'h6D);                 // R3 = M[7]
        chk_reg(3, 8'h03, "t5_m7_written");
        issue(8'h14);                   // R0 = R1 + R1, interrupted
        #1;
        reset = 1'b0;
        #1;
        check_eq("t5_async_busy", busy, 1'b0);
        check_eq("t5_async_pc", pc, 8'h00);
        check_eq("t5_async_ret", retired, 16'd0);
        @(negedge CLK);
        reset = 1'b1;
        @(posedge CLK);
        #1;
        chk_reg(0, 8'h00, "t5_target_r0");
        check_eq("t5_after_val", reg_write_val, 8'h00);
        do_step(8'h47);
        do_step(8'h16);
        do_step(8'h6D);                 // R3 = M[7]
        chk_reg(3, 8'h07, "t5_m7_restored");
        check_eq("t5_final_pc", pc, 8'h03);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/param_step_cpu.md
Name: param_step_cpu

Overview:
- Parametrised multi-cycle accumulator-free load/store CPU core; successor of the fixed 8-bit, 4-register stepped processor in the final-project top level.
- Executes one instruction per external step pulse. Instructions come from an external ROM via a valid/ready handshake.
- Adds a halt state, a carry flag, a retired-instruction counter and a generalised one-hot debug view.
- Sits between the board-level frequency divider (step source) and the hex-display decoders.

Parameters:
- DATA_W, 8: register and data-memory word width.
- RA_W, 2: register-address width; NREG = 2**RA_W registers.
- DMEM_AW, 5: data-memory address width; depth = 2**DMEM_AW words.
- PC_W, 8: program-counter width; must be <= DATA_W.
- CNT_W, 16: retired-instruction counter width.
- Derived (not overridable): INSTR_W = 2 + 3*RA_W.

Ports:
- CLK  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- step  in  1  single-cycle advance request, synchronous to CLK.
- instr  in  INSTR_W  instruction word for address pc.
- instr_valid  in  1  instr is valid for the current pc.
- pc  out  PC_W  instruction fetch address.
- instr_ready  out  1  core is idle and will accept step.
- reg_write_stb  out  1  one-cycle pulse on register writeback.
- reg_write_val  out  DATA_W  last value written to a register; held between writes.
- carry  out  1  carry-out of the last ADD.
- halted  out  1  core is in HALT.
- busy  out  1  core is in EXEC.
- retired  out  CNT_W  count of retired instructions.
- dbg_sel  in  NREG+1  one-hot view select; bit NREG selects pc, bit i selects register i.
- dbg_data  out  DATA_W  selected value.

Behaviour:
- Encoding: op = instr[INSTR_W-1 -: 2]; fields fA, fB, fC of RA_W bits each, from MSB to LSB below op.
  - op 00 ADD: R[fC] = R[fA] + R[fB]. carry = bit DATA_W of the (DATA_W+1)-bit sum. Operands are read before the write, so fC == fA is legal.
  - op 01 LOAD: R[fB] = M[addr].
  - op 10 STORE: M[addr] = R[fB].
  - Load/store address: addr = (R[fA] + zero-extended fC) mod 2**DMEM_AW, wrapping silently.
  - op 11 JUMP on fC[1:0]:
    - 00: pc + 1.
    - 01: pc + 2.
    - 10: pc - 1.
    - 11: HALT; pc is unchanged.
    - Upper bits of fC are ignored.
- pc arithmetic is modulo 2**PC_W in both directions; pc - 1 from 0 gives all ones.
- States:
  - IDLE: instr_ready = !halted.
    - step && instr_valid latches instr and moves to EXEC.
    - step without instr_valid is ignored; no state change.
  - EXEC: busy = 1. All architectural updates occur at the end of this single cycle, then return to IDLE. The HALT jump goes to HALT instead.
  - HALT: halted = 1, instr_ready = 0. Ignores step and instr_valid; exits only via reset.
- Latency: step accepted at edge N; results (register, memory, pc, retired) are visible after edge N+1; instr_ready reasserts in cycle N+1.
- Steps arriving during EXEC are dropped; there is no queueing.
- reg_write_stb pulses in the cycle after EXEC for ADD and LOAD only. reg_write_val updates with it.
- STORE and JUMP leave reg_write_val and carry unchanged. LOAD does not affect carry.
- retired increments by 1 for every instruction leaving EXEC, including the HALT jump, and wraps at 2**CNT_W.
- dbg_data is combinational:
  - exactly one dbg_sel bit set: the selected register, or pc zero-extended;
  - any other pattern, including zero: all ones.
- Reset (reset low, asynchronous) takes effect immediately, including mid-EXEC, and no partial update survives:
  - state = IDLE; pc = 0; all R = 0; M[i] = i[3:0] zero-extended;
  - reg_write_val = 0; reg_write_stb = 0; carry = 0; retired = 0; halted = 0; busy = 0.
- Deassertion of reset must be synchronised by the instantiating level. The core needs a clean edge only.

Test Plan:
1. Reset, then step with instr_valid=1 for LOAD R1,[R0+3] (01_00_01_11) -> after 2 edges R1=3, reg_write_stb one pulse, reg_write_val=3, pc=1, retired=1.
2. With R1=3, ADD R2=R1+R1 (00_01_01_10) then ADD R3=R2+R2 -> R2=6, R3=12, carry=0. Preload R1=0xFF, ADD R1=R1+R1 -> R1=0xFE, carry=1.
3. With R1=0x1F, STORE R1,[R1+2] then LOAD R0,[R1+2] -> wraps to address 1; M[1]=0x1F, R0=0x1F; reg_write_stb pulses only for the LOAD.
4. JUMP 10 at pc=0 -> pc=0xFF. JUMP 01 -> pc=0x01. Step with instr_valid=0 -> no change, retired unchanged. Step asserted during EXEC -> dropped.
5. JUMP 11 at pc=5 -> halted=1, pc=5, retired +1; further steps are ignored. Pull reset low mid-EXEC of an ADD -> target register stays 0, pc=0, M[7]=7.
6. dbg_sel 00001 with R0=0x1F -> 0x1F. 10000 with pc=5 -> 0x05. 00011 -> 0xFF. 00000 -> 0xFF.
